// File: rtl/mask_encoder16_if.sv
// mask_encoder16_if: mask-in / index-out valid-ready handshakes of the sparse index encoder.
interface mask_encoder16_if #(parameter int N = 16, parameter int CW = 4);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_mask;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_code;
    logic          out_last;
    modport master (output in_valid, in_mask, out_ready, input in_ready, out_valid, out_code, out_last);
    modport slave  (input in_valid, in_mask, out_ready, output in_ready, out_valid, out_code, out_last);
endinterface

// File: rtl/mask_encoder16.sv
// mask_encoder16: emits the index of every set bit of an accepted 16-bit mask, lowest first, one per beat.
module mask_encoder16 #(
    parameter int N  = 16,
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            rst,
    mask_encoder16_if.slave bus,
    output logic            done,
    output logic            zero_mask,
    output logic            busy
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t        state_q, state_d;
    logic [N-1:0]  pend_q, pend_d;
    logic          done_q, done_d, zero_q, zero_d;
    logic [CW-1:0] code;
    logic          last;
    // Outputs decode from state/pend only, so no input reaches an output combinationally.
    always_comb begin
        code = '0;
        for (int i = N - 1; i >= 0; i--) code = pend_q[i] ? CW'(i) : code;
        last = (state_q == SCAN) && (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);
    end
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == SCAN);
    assign bus.out_code  = code;
    assign bus.out_last  = last;
    assign busy          = (state_q == SCAN);
    assign done          = done_q;
    assign zero_mask     = zero_q;
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        zero_d  = 1'b0;
        if (state_q == IDLE && bus.in_valid) begin
            pend_d  = bus.in_mask;
            state_d = (bus.in_mask != '0) ? SCAN : IDLE;
            zero_d  = (bus.in_mask == '0);
        end
        if (state_q == SCAN && bus.out_ready) begin
            pend_d  = pend_q & ~(N'(1) << code);
            state_d = last ? IDLE : SCAN;
            done_d  = last;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_mask_encoder16.sv
// tb_mask_encoder16: randomized and directed masks checked against a per-bit index list model.
module tb_mask_encoder16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done, zero_mask, busy;
    int   n_cmp = 0;
    int   n_err = 0;
    mask_encoder16_if #(.N(16), .CW(4)) bus ();
    mask_encoder16 dut (.clk(clk), .rst(rst), .bus(bus), .done(done), .zero_mask(zero_mask), .busy(busy));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    always @(negedge clk) if (!rst) begin
        chk("excl_done_zero", done && zero_mask, 0);
        chk("excl_done_valid", done && bus.out_valid, 0);
    end
    task automatic send_mask(input logic [15:0] m, input int stall, input bit rnd, input bit noise);
        int q[$];
        int cyc;
        bit rdy;
        for (int i = 0; i < 16; i++) if (m[i]) q.push_back(i);
        @(negedge clk);
        chk("idle_ready", bus.in_ready, 1);
        chk("idle_valid", bus.out_valid, 0);
        chk("idle_done", done, 0);
        bus.in_valid = 1'b1;
        bus.in_mask = m;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (m == 16'h0) begin
            chk("zero_pulse", zero_mask, 1);
            chk("zero_valid", bus.out_valid, 0);
            chk("zero_done", done, 0);
            chk("zero_ready", bus.in_ready, 1);
            @(negedge clk);
            chk("zero_end", zero_mask, 0);
            chk("zero_valid2", bus.out_valid, 0);
            return;
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            chk("scan_valid", bus.out_valid, 1);
            chk("scan_ready", bus.in_ready, 0);
            chk("scan_busy", busy, 1);
            chk("scan_code", bus.out_code, q[0]);
            chk("scan_last", bus.out_last, q.size() == 1);
            chk("scan_done", done, 0);
            rdy = (cyc >= stall) && (!rnd || $urandom_range(3) != 0);
            bus.out_ready = rdy;
            bus.in_valid = noise && !(rdy && q.size() == 1);
            bus.in_mask = noise ? 16'($urandom) : 16'h0;
            @(negedge clk);
            if (rdy) void'(q.pop_front());
            cyc++;
        end
        if (q.size() != 0) chk("scan_timeout", q.size(), 0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_valid", bus.out_valid, 0);
        chk("done_ready", bus.in_ready, 1);
        chk("done_busy", busy, 0);
        chk("done_zero", zero_mask, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        bus.in_valid = 1'b0;
        bus.in_mask = 16'h0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_code", bus.out_code, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_zero", zero_mask, 0);
        rst = 1'b0;
        send_mask(16'h0001, 0, 0, 0);
        send_mask(16'h8421, 0, 0, 0);
        send_mask(16'h00A0, 3, 0, 0);
        send_mask(16'h0000, 0, 0, 0);
        send_mask(16'hFFFF, 0, 0, 1);
        // Reset arrives asynchronously mid-scan, between clock edges.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mask = 16'hF000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mid_code12", bus.out_code, 12);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mid_code13", bus.out_code, 13);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_code", bus.out_code, 0);
        chk("mid_rst_last", bus.out_last, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        chk("mid_rst_done", done, 0);
        bus.out_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        send_mask(16'h0002, 0, 0, 0);
        for (int t = 0; t < 40; t++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if (t % 8 == 0) m = 16'h0;
            if (t % 8 == 1) m = 16'h1 << $urandom_range(15);
            send_mask(m, $urandom_range(2), t % 2 == 1, t % 3 == 0);
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mask_encoder16.md
Name: mask_encoder16

Overview:
- Sequential 16-to-4 index encoder, the inverse of the team's 4-to-16 one-hot decoder.
- Accepts a 16-bit mask, for example a nonzero-activation or valid-lane mask, through a valid/ready handshake.
- Emits the 4-bit index of every set bit, one index per accepted output beat, in ascending order.
- Sits between the mask generator and the sparse PE address path, and flags the last index of each mask.

Parameters:
- N, 16, mask width. Fixed at 16; other values unsupported.
- CW, 4, code width. Must equal log2(N).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_mask is valid.
- in_ready  output  1  block can accept a mask.
- in_mask  input  16  mask to encode.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code.
- out_code  output  4  index of the current lowest pending set bit.
- out_last  output  1  out_code is the final index of this mask.
- done  output  1  one-cycle pulse after the last index handshakes.
- zero_mask  output  1  one-cycle pulse when an all-zero mask is accepted.
- busy  output  1  state is SCAN.

Behaviour:
- Registers:
  - state (IDLE/SCAN), pend[15:0], done, zero_mask.
  - in_ready, out_valid, out_code, out_last and busy are decoded from state/pend only, with no combinational path from any input.
- Reset (async, any time, including mid-scan):
  - state=IDLE, pend=0, done=0, zero_mask=0.
  - Hence in_ready=1, out_valid=0, out_code=0, out_last=0, busy=0.
  - A scan interrupted by reset produces no done pulse.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready with in_mask!=0: pend<=in_mask, state<=SCAN.
  - On in_valid&&in_ready with in_mask==0: stay in IDLE, zero_mask=1 in the next cycle for one cycle, no out_valid.
- SCAN:
  - in_ready=0; in_valid is ignored (the mask is not captured).
  - out_valid=1.
  - out_code = index of the lowest set bit of pend (bit 0 has priority).
  - out_last = 1 iff pend has exactly one bit set.
  - On out_valid&&out_ready: clear bit out_code in pend.
  - If out_last was 1 on that handshake: state<=IDLE and done=1 in the next cycle for one cycle.
- Backpressure: while out_valid && !out_ready, pend, out_code and out_last hold stable.
- Latency and throughput:
  - Mask accepted at edge t gives the first out_valid in cycle t+1.
  - With out_ready held high, a mask with k set bits emits k consecutive beats.
  - in_ready returns high the cycle after the last handshake: one-cycle bubble, no same-cycle reload.
  - Worst case, mask 0xFFFF: 16 beats, then 1 idle cycle.
- Invariants:
  - Codes are strictly increasing within a mask; no duplicates.
  - The OR of the one-hot expansions of all emitted codes equals the accepted mask.
  - out_last is asserted on exactly one beat per nonzero mask.
  - done and zero_mask are never both high.
  - done never coincides with out_valid.

Test Plan:
- Reset release, then in_mask=0x0001 with out_ready=1 -> single beat code=0, last=1; done pulses the next cycle; in_ready=1 the cycle after the beat.
- in_mask=0x8421, out_ready=1 -> codes 0,5,10,15 on 4 consecutive cycles; out_last only on 15; then done pulse.
- in_mask=0x00A0, out_ready low for 3 cycles then high -> code=5 held stable 3 cycles with out_valid=1; then codes 5,7; last on 7.
- in_mask=0x0000 -> zero_mask pulses 1 cycle; out_valid stays 0; done stays 0; in_ready stays 1.
- in_mask=0xFFFF, out_ready=1 -> codes 0..15 in order over 16 cycles; in_valid=1 with in_mask=0x0003 during the scan is ignored; next mask accepted only after the bubble.
- in_mask=0xF000, assert rst after the first beat (code 12) -> out_valid=0 immediately, pend=0, no done pulse; after release in_mask=0x0002 -> code=1, last=1.
